// File: rtl/wb_pkg.sv
// Shared types for the vertex writeback stage: FSM states, the FIFO entry
// layout and the byte-shift helper that turns a vertex index into a byte offset.
package wb_pkg;

    localparam int unsigned WB_DATA_WIDTH = 64;
    localparam int unsigned WB_ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_RUN,
        WB_DRAIN,
        WB_DONE
    } wb_state_t;

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;

    function automatic int unsigned wb_byte_shift(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    localparam int unsigned WB_BYTE_SHIFT = wb_byte_shift(WB_DATA_WIDTH);

endpackage

// File: rtl/wb_fifo.sv
// Posted-write FIFO for the writeback stage. Pointers carry an extra wrap bit
// so full and empty are told apart without a separate occupancy counter.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter type         T     = wb_entry_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic pop_i,
    input  T     data_i,
    output logic full_o,
    output logic empty_o,
    output T     head_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    T               r_mem [DEPTH];
    logic [PW:0]    r_wr_ptr;
    logic [PW:0]    r_rd_ptr;
    logic           w_push;
    logic           w_pop;

    assign empty_o = (r_wr_ptr == r_rd_ptr);
    assign full_o  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign head_o  = r_mem[r_rd_ptr[PW-1:0]];

    // A pop in the same cycle frees the slot, so push is legal even when full.
    assign w_push = push_i & (~full_o | pop_i);
    assign w_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= data_i;
    end

endmodule

// File: rtl/vertex_writeback.sv
// Writes flagged vertices back to DRAM through a posted-write FIFO and reports
// per-iteration update count / convergence. WB_SKIP_CNT_EN adds skip_cnt_o.
module vertex_writeback
    import wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [CNT_WIDTH-1:0]  num_vert_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  flag_i,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ack_i,
    output logic                  done_o,
    output logic                  changed_o,
    output logic [CNT_WIDTH-1:0]  update_cnt_o
`ifdef WB_SKIP_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  skip_cnt_o
`endif
);

    localparam int unsigned BYTE_SHIFT = wb_byte_shift(DATA_WIDTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    wb_state_t              r_state;
    wb_state_t              w_state_next;
    logic [ADDR_WIDTH-1:0]  r_base;
    logic [CNT_WIDTH-1:0]   r_num;
    logic [CNT_WIDTH-1:0]   r_idx;
    logic [CNT_WIDTH-1:0]   r_upd_cnt;

    logic                   w_start;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_last;
    logic                   w_full;
    logic                   w_empty;
    logic [ADDR_WIDTH-1:0]  w_offset;
    entry_t                 w_push_entry;
    entry_t                 w_head;

    assign w_start  = (r_state == WB_IDLE) & start_i;
    assign w_accept = valid_i & ready_o;
    assign w_push   = w_accept & flag_i;
    assign w_last   = (r_idx == r_num - CNT_WIDTH'(1));

    // Index is resized to the address width before shifting, so the address wraps.
    assign w_offset           = ADDR_WIDTH'(r_idx) << BYTE_SHIFT;
    assign w_push_entry.addr  = r_base + w_offset;
    assign w_push_entry.data  = data_i;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .pop_i   (mem_ack_i),
        .data_i  (w_push_entry),
        .full_o  (w_full),
        .empty_o (w_empty),
        .head_o  (w_head)
    );

    assign mem_req_o    = ~w_empty;
    assign mem_addr_o   = w_empty ? '0 : w_head.addr;
    assign mem_wdata_o  = w_empty ? '0 : w_head.data;
    assign changed_o    = (r_upd_cnt != '0);
    assign update_cnt_o = r_upd_cnt;

    always_ff @(posedge clk) begin
        if (rst) r_state <= WB_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        ready_o      = 1'b0;
        done_o       = 1'b0;
        case (r_state)
            WB_IDLE: begin
                if (start_i) w_state_next = (num_vert_i == '0) ? WB_DRAIN : WB_RUN;
            end
            WB_RUN: begin
                ready_o = ~w_full;
                if (w_accept && w_last) w_state_next = WB_DRAIN;
            end
            WB_DRAIN: begin
                if (w_empty) w_state_next = WB_DONE;
            end
            WB_DONE: begin
                done_o       = 1'b1;
                w_state_next = WB_IDLE;
            end
            default: w_state_next = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base    <= '0;
            r_num     <= '0;
            r_idx     <= '0;
            r_upd_cnt <= '0;
        end else if (w_start) begin
            r_base    <= base_addr_i;
            r_num     <= num_vert_i;
            r_idx     <= '0;
            r_upd_cnt <= '0;
        end else if (w_accept) begin
            r_idx <= r_idx + CNT_WIDTH'(1);
            if (flag_i && (r_upd_cnt != '1)) r_upd_cnt <= r_upd_cnt + CNT_WIDTH'(1);
        end
    end

`ifdef WB_SKIP_CNT_EN
    logic [CNT_WIDTH-1:0] r_skip_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_skip_cnt <= '0;
        end else if (w_start) begin
            r_skip_cnt <= '0;
        end else if (w_accept && !flag_i && (r_skip_cnt != '1)) begin
            r_skip_cnt <= r_skip_cnt + CNT_WIDTH'(1);
        end
    end

    assign skip_cnt_o = r_skip_cnt;
`endif

endmodule

// File: tb/tb_vertex_writeback.sv
// Directed bench for vertex_writeback (FIFO_DEPTH=2 so back-pressure is easy to reach).
module tb_vertex_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic [31:0] num_vert_i;
    logic        valid_i;
    logic        ready_o;
    logic [63:0] data_i;
    logic        flag_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic        mem_ack_i;
    logic        done_o;
    logic        changed_o;
    logic [31:0] update_cnt_o;
`ifdef WB_SKIP_CNT_EN
    logic [31:0] skip_cnt_o;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int req_cnt  = 0;
    logic [31:0] wq_addr [$];
    logic [63:0] wq_data [$];

    vertex_writeback #(
        .DATA_WIDTH (64),
        .ADDR_WIDTH (32),
        .CNT_WIDTH  (32),
        .FIFO_DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .num_vert_i   (num_vert_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_i       (data_i),
        .flag_i       (flag_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ack_i    (mem_ack_i),
        .done_o       (done_o),
        .changed_o    (changed_o),
        .update_cnt_o (update_cnt_o)
`ifdef WB_SKIP_CNT_EN
        ,
        .skip_cnt_o   (skip_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Memory-side monitor: record completed writes, request cycles and done pulses.
    always @(posedge clk) begin
        if (mem_req_o && mem_ack_i) begin
            wq_addr.push_back(mem_addr_o);
            wq_data.push_back(mem_wdata_o);
        end
        if (mem_req_o) req_cnt++;
        if (done_o) done_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_iter(input logic [31:0] base, input logic [31:0] num);
        base_addr_i = base;
        num_vert_i  = num;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
    endtask

    task automatic push_vertex(input string tag, input logic [63:0] d, input logic f);
        bit ok = 1'b0;
        valid_i = 1'b1;
        data_i  = d;
        flag_i  = f;
        for (int n = 0; n < 100; n++) begin
            if (ready_o) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        valid_i = 1'b0;
        check(tag, 64'(ok), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    task automatic clear_mon();
        wq_addr.delete();
        wq_data.delete();
        done_cnt = 0;
        req_cnt  = 0;
    endtask

    logic [63:0] d1 [4] = '{64'hA000_0000_0000_0000, 64'hA111_1111_1111_1111,
                            64'hA222_2222_2222_2222, 64'hA333_3333_3333_3333};
    logic [63:0] d4 [5] = '{64'h4000_0000_0000_0010, 64'h4000_0000_0000_0011,
                            64'h4000_0000_0000_0012, 64'h4000_0000_0000_0013,
                            64'h4000_0000_0000_0014};
    logic [63:0] d5 [3] = '{64'h5555_0000_0000_0000, 64'h5555_0000_0000_0001,
                            64'h5555_0000_0000_0002};
    logic [31:0] a5 [3] = '{32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'h0000_0000};

    initial begin
        int acc;
        rst = 1'b1; start_i = 1'b0; base_addr_i = '0; num_vert_i = '0;
        valid_i = 1'b0; data_i = '0; flag_i = 1'b0; mem_ack_i = 1'b0;
        tick(); tick();

        check("rst_ready",   64'(ready_o),      64'd0);
        check("rst_req",     64'(mem_req_o),    64'd0);
        check("rst_done",    64'(done_o),       64'd0);
        check("rst_changed", 64'(changed_o),    64'd0);
        check("rst_upd",     64'(update_cnt_o), 64'd0);
        check("rst_addr",    64'(mem_addr_o),   64'd0);
        check("rst_wdata",   mem_wdata_o,       64'd0);
        rst = 1'b0;
        tick();

        // 1: mixed flags, ack every cycle
        clear_mon();
        mem_ack_i = 1'b1;
        start_iter(32'h1000, 32'd4);
        push_vertex("t1_acc0", d1[0], 1'b1);
        check("t1_lat_req",  64'(mem_req_o),  64'd1);
        check("t1_lat_addr", 64'(mem_addr_o), 64'h1000);
        push_vertex("t1_acc1", d1[1], 1'b0);
        push_vertex("t1_acc2", d1[2], 1'b1);
        push_vertex("t1_acc3", d1[3], 1'b1);
        wait_done("t1_done");
        check("t1_upd",     64'(update_cnt_o), 64'd3);
        check("t1_changed", 64'(changed_o),    64'd1);
        tick();
        check("t1_done_pulse", 64'(done_o), 64'd0);
        tick();
        check("t1_done_cnt", 64'(done_cnt),        64'd1);
        check("t1_nwrites",  64'(wq_addr.size()),  64'd3);
        if (wq_addr.size() == 3) begin
            check("t1_a0", 64'(wq_addr[0]), 64'h1000);
            check("t1_d0", wq_data[0], d1[0]);
            check("t1_a1", 64'(wq_addr[1]), 64'h1010);
            check("t1_d1", wq_data[1], d1[2]);
            check("t1_a2", 64'(wq_addr[2]), 64'h1018);
            check("t1_d2", wq_data[2], d1[3]);
        end

        // 2: nothing flagged
        clear_mon();
        start_iter(32'h2000, 32'd3);
        for (int i = 0; i < 3; i++) push_vertex("t2_acc", 64'(i), 1'b0);
        wait_done("t2_done");
        check("t2_req_cycles", 64'(req_cnt),       64'd0);
        check("t2_changed",    64'(changed_o),     64'd0);
        check("t2_upd",        64'(update_cnt_o),  64'd0);
`ifdef WB_SKIP_CNT_EN
        check("t2_skip", 64'(skip_cnt_o), 64'd3);
`endif
        tick();

        // 3: empty iteration, done two cycles after start
        clear_mon();
        start_iter(32'h3000, 32'd0);
        check("t3_ready_c1", 64'(ready_o), 64'd0);
        check("t3_done_c1",  64'(done_o),  64'd0);
        tick();
        check("t3_ready_c2", 64'(ready_o), 64'd0);
        check("t3_done_c2",  64'(done_o),  64'd1);
        tick();
        check("t3_done_c3",  64'(done_o),  64'd0);
        check("t3_done_cnt", 64'(done_cnt), 64'd1);

        // 4: back-pressure with ack held low, then release
        clear_mon();
        mem_ack_i = 1'b0;
        start_iter(32'h4000, 32'd5);
        acc = 0;
        valid_i = 1'b1; flag_i = 1'b1; data_i = d4[0];
        repeat (4) begin
            if (ready_o) acc++;
            tick();
            data_i = d4[acc];
        end
        check("t4_acc_stall", 64'(acc),        64'd2);
        check("t4_ready_low", 64'(ready_o),    64'd0);
        check("t4_req",       64'(mem_req_o),  64'd1);
        check("t4_addr_a",    64'(mem_addr_o), 64'h4000);
        tick(); tick();
        check("t4_addr_b",    64'(mem_addr_o), 64'h4000);
        check("t4_wdata_b",   mem_wdata_o,     d4[0]);
        check("t4_no_write",  64'(wq_addr.size()), 64'd0);
        mem_ack_i = 1'b1;
        for (int n = 0; n < 60 && acc < 5; n++) begin
            if (ready_o) acc++;
            tick();
            if (acc < 5) data_i = d4[acc];
        end
        valid_i = 1'b0;
        check("t4_acc_all", 64'(acc), 64'd5);
        wait_done("t4_done");
        check("t4_upd",      64'(update_cnt_o),   64'd5);
        check("t4_nwrites",  64'(wq_addr.size()), 64'd5);
        if (wq_addr.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check("t4_addr", 64'(wq_addr[i]), 64'h4000 + 64'(i * 8));
                check("t4_data", wq_data[i], d4[i]);
            end
        end
        tick();

        // 5: address wrap
        clear_mon();
        start_iter(32'hFFFF_FFF0, 32'd3);
        for (int i = 0; i < 3; i++) push_vertex("t5_acc", d5[i], 1'b1);
        wait_done("t5_done");
        check("t5_nwrites", 64'(wq_addr.size()), 64'd3);
        if (wq_addr.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("t5_addr", 64'(wq_addr[i]), 64'(a5[i]));
                check("t5_data", wq_data[i], d5[i]);
            end
        end
        tick();

        // 6: reset mid-iteration with requests pending, then a clean run
        clear_mon();
        mem_ack_i = 1'b0;
        start_iter(32'h5000, 32'd4);
        push_vertex("t6_acc0", 64'h66, 1'b1);
        push_vertex("t6_acc1", 64'h67, 1'b1);
        check("t6_req_pend", 64'(mem_req_o),    64'd1);
        check("t6_upd_pre",  64'(update_cnt_o), 64'd2);
        rst = 1'b1;
        tick();
        check("t6_rst_req",   64'(mem_req_o),    64'd0);
        check("t6_rst_upd",   64'(update_cnt_o), 64'd0);
        check("t6_rst_ready", 64'(ready_o),      64'd0);
        check("t6_rst_addr",  64'(mem_addr_o),   64'd0);
        rst = 1'b0;
        mem_ack_i = 1'b1;
        tick();
        clear_mon();
        start_iter(32'h6000, 32'd2);
        push_vertex("t6_acc2", 64'h70, 1'b1);
        push_vertex("t6_acc3", 64'h71, 1'b1);
        wait_done("t6_done");
        check("t6_upd",     64'(update_cnt_o),   64'd2);
        check("t6_nwrites", 64'(wq_addr.size()), 64'd2);
        if (wq_addr.size() == 2) begin
            check("t6_a0", 64'(wq_addr[0]), 64'h6000);
            check("t6_d0", wq_data[0], 64'h70);
            check("t6_a1", 64'(wq_addr[1]), 64'h6008);
            check("t6_d1", wq_data[1], 64'h71);
        end
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
